// File: rtl/display_pkg.sv
// Shared constants, converter state encoding and BCD helper for the score display.
package display_pkg;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [13:0] SCORE_MAX  = 14'd9999;
    localparam int unsigned BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/done handshake.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [13:0] i_bin,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_bcd
);

    conv_state_t r_state, w_next;
    logic [13:0] r_bin;
    logic [15:0] r_acc;
    logic [15:0] w_acc_adj;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        w_accept;

    // busy lags IDLE by one cycle, so a strobe is only taken once busy=0 is seen
    assign w_accept = i_start && (r_state == IDLE) && !r_busy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SHIFT;
            SHIFT:   if (r_cnt == 4'd13) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_acc_adj = '0;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            w_acc_adj[4*i +: 4] = add3(r_acc[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_bin   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_accept || (r_state != IDLE);
            if (w_accept) begin
                r_bin <= (i_bin > SCORE_MAX) ? SCORE_MAX : i_bin;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                {r_acc, r_bin} <= {w_acc_adj, r_bin} << 1;
                r_cnt          <= r_cnt + 4'd1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = (r_state == DONE);
    assign o_bcd  = r_acc;

endmodule

// File: rtl/score_display_driver.sv
// Converts the score to BCD and time-multiplexes four digits onto a common-anode display.
module score_display_driver
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        update,
    output logic        busy,
    output logic [3:0]  digit,
    output logic [3:0]  an
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic             w_done;
    logic [15:0]      w_bcd;
    logic [15:0]      r_disp;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic             w_wrap;
    logic [3:0]       w_blank;
    logic [3:0]       r_an;
    logic [3:0]       r_digit;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (update),
        .i_bin   (score),
        .o_busy  (busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    assign w_wrap     = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;

    // digit k is blank when it and every more significant nibble are zero
    always_comb begin
        w_blank = '0;
        for (int unsigned k = 1; k < BCD_DIGITS; k++) begin
            w_blank[k] = BLANK_LZ && ((r_disp >> (4 * k)) == 16'd0);
        end
    end

    // an/digit are reloaded every cycle from the upcoming index so they switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp  <= '0;
            r_div   <= '0;
            r_idx   <= '0;
            r_an    <= 4'b1110;
            r_digit <= 4'h0;
        end else begin
            if (w_done) r_disp <= w_bcd;
            r_div   <= w_wrap ? '0 : r_div + DIV_W'(1);
            r_idx   <= w_idx_next;
            r_an    <= ~(4'b0001 << w_idx_next);
            r_digit <= w_blank[w_idx_next] ? BLANK_CODE : r_disp[{w_idx_next, 2'b00} +: 4];
        end
    end

    assign an    = r_an;
    assign digit = r_digit;

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench: two instances (leading-zero blanking on/off) driven by shared stimulus.
module tb_score_display_driver;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        update;
    logic [13:0] score;
    logic        busy0, busy1;
    logic [3:0]  dig0, dig1, an0, an1;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    always #5 clk = ~clk;

    score_display_driver #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut_blank (
        .clk(clk), .rst(rst), .score(score), .update(update),
        .busy(busy0), .digit(dig0), .an(an0)
    );

    score_display_driver #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut_noblank (
        .clk(clk), .rst(rst), .score(score), .update(update),
        .busy(busy1), .digit(dig1), .an(an1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // exp holds the expected digit codes, nibble k = digit on anode k
    task automatic scan_check(input string tag, input bit nb, input logic [15:0] exp);
        int unsigned n;
        logic [3:0]  a, d, ea;
        n = 0;
        a = nb ? an1 : an0;
        while (a !== 4'b1110 && n < 4 * DIV + 4) begin
            tick();
            n++;
            a = nb ? an1 : an0;
        end
        for (int k = 0; k < 4; k++) begin
            a  = nb ? an1 : an0;
            d  = nb ? dig1 : dig0;
            ea = ~(4'b0001 << k);
            chk($sformatf("%s_an%0d", tag, k), 16'(a), 16'(ea));
            chk($sformatf("%s_dig%0d", tag, k), 16'(d), 16'(exp[4*k +: 4]));
            repeat (DIV) tick();
        end
    endtask

    task automatic convert(input logic [13:0] s, input string tag);
        int unsigned n;
        score  = s;
        update = 1'b1;
        tick();
        update = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 16'(n), 16'd16);
    endtask

    initial begin
        int unsigned n;
        rst    = 1'b1;
        update = 1'b0;
        score  = '0;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_busy", 16'(busy0), 16'd0);
        chk("rst_an", 16'(an0), 16'h000E);
        chk("rst_digit", 16'(dig0), 16'h0000);
        scan_check("idle_blank", 1'b0, 16'hFFF0);
        scan_check("idle_nb", 1'b1, 16'h0000);

        convert(14'd1234, "c1234");
        scan_check("s1234", 1'b0, 16'h1234);
        scan_check("s1234_nb", 1'b1, 16'h1234);

        convert(14'd7, "c7");
        scan_check("s7", 1'b0, 16'hFFF7);
        scan_check("s7_nb", 1'b1, 16'h0007);

        convert(14'd1005, "c1005");
        scan_check("s1005", 1'b0, 16'h1005);

        convert(14'h3FFF, "c16383");
        scan_check("s16383", 1'b0, 16'h9999);

        convert(14'd9999, "c9999");
        scan_check("s9999", 1'b0, 16'h9999);

        convert(14'd0, "c0");
        scan_check("s0", 1'b0, 16'hFFF0);

        // strobes at N+3 and N+10 of the busy window must be dropped
        score  = 14'd42;
        update = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            score  = 14'd8765;
            update = (i == 3 || i == 10);
            tick();
        end
        update = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("ign_busy_low", 16'(busy0), 16'd0);
        repeat (3) tick();
        chk("ign_still_idle", 16'(busy0), 16'd0);
        scan_check("s42", 1'b0, 16'hFF42);
        convert(14'd8765, "c8765");
        scan_check("s8765", 1'b0, 16'h8765);

        // reset at N+8 of a conversion aborts it and restarts the scan
        score  = 14'd4321;
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 16'(busy0), 16'd0);
        chk("abort_an", 16'(an0), 16'h000E);
        chk("abort_digit", 16'(dig0), 16'h0000);
        chk("abort_digit_nb", 16'(dig1), 16'h0000);
        repeat (DIV - 1) tick();
        chk("abort_an_hold", 16'(an0), 16'h000E);
        tick();
        chk("abort_an_adv", 16'(an0), 16'h000D);
        chk("abort_dig1_blank", 16'(dig0), 16'h000F);
        chk("abort_dig1_nb", 16'(dig1), 16'h0000);
        chk("abort_busy_after", 16'(busy0), 16'd0);
        scan_check("s_abort", 1'b0, 16'hFFF0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
